// File: rtl/cod5_fifo_pkg.sv
// Shared FIFO helpers: width functions and flag reset values.
// Used by cod5_sync_fifo and its RAM; kept generic for the async variant.
// No logic; constants and constant functions only.
package cod5_fifo_pkg;

    localparam int MAX_DEPTH = 1024;

    localparam logic FULL_RST         = 1'b0;
    localparam logic ALMOST_FULL_RST  = 1'b0;
    localparam logic EMPTY_RST        = 1'b1;
    localparam logic ALMOST_EMPTY_RST = 1'b1;

    // Minimum bits to hold values 0..value-1; never less than 1.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

    // Count must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return clog2(depth + 1);
    endfunction

endpackage

// File: rtl/cod5_fifo_ram.sv
// Simple dual-port RAM: synchronous write, read port combinational (FWFT=1) or registered (FWFT=0).
// Latency: write visible next cycle; read 0 cycles (comb) or 1 cycle (registered).
// Backpressure: none; the controlling FIFO gates wr_en/rd_en.
module cod5_fifo_ram
    import cod5_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 24,
    parameter int FWFT       = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      wr_en,
    input  logic [clog2(DEPTH)-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic                      rd_en,
    input  logic [clog2(DEPTH)-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]     rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    if (FWFT != 0) begin : g_comb_rd
        // rd_en acts as an output qualifier here so an empty FIFO shows zero.
        logic unused_rst;
        assign unused_rst = rst_ni;
        assign rd_data    = rd_en ? mem[rd_addr] : '0;
    end else begin : g_reg_rd
        logic [DATA_WIDTH-1:0] rd_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rd_q <= '0;
            end else if (rd_en) begin
                rd_q <= mem[rd_addr];
            end
        end
        assign rd_data = rd_q;
    end

endmodule

// File: rtl/cod5_sync_fifo.sv
// Single-clock FIFO, any depth 2..1024, registered count and flags; optional sticky errors (COD5_SYNC_FIFO_ERR_EN).
// Latency: write-to-visible 1 cycle (FWFT=1); FWFT=0 read data 1 cycle after an accepted pop.
// Backpressure: writes dropped while full, reads ignored while empty; clear_i overrides both.
module cod5_sync_fifo
    import cod5_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int DEPTH        = 24,
    parameter int ALMOST_FULL  = 4,
    parameter int ALMOST_EMPTY = 4,
    parameter int FWFT         = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    input  logic                          write_inc_i,
    input  logic [DATA_WIDTH-1:0]         write_data_i,
    output logic                          write_full_o,
    output logic                          write_almost_full_o,
    input  logic                          read_inc_i,
    output logic [DATA_WIDTH-1:0]         read_data_o,
    output logic                          read_empty_o,
    output logic                          read_almost_empty_o,
    output logic [cnt_width(DEPTH)-1:0]   nb_data_o,
    output logic                          overflow_o,
    output logic                          underflow_o
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(DEPTH - ALMOST_FULL);
    localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(ALMOST_EMPTY);

    if (DEPTH < 2 || DEPTH > MAX_DEPTH) begin : g_bad_depth
        $error("cod5_sync_fifo: DEPTH must be in 2..1024");
    end
    if (ALMOST_FULL < 0 || ALMOST_FULL >= DEPTH) begin : g_bad_af
        $error("cod5_sync_fifo: ALMOST_FULL must be in 0..DEPTH-1");
    end
    if (ALMOST_EMPTY < 0 || ALMOST_EMPTY >= DEPTH) begin : g_bad_ae
        $error("cod5_sync_fifo: ALMOST_EMPTY must be in 0..DEPTH-1");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
        $error("cod5_sync_fifo: FWFT must be 0 or 1");
    end

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             full_q, afull_q, empty_q, aempty_q;
    logic             wr_acc, rd_acc;
    logic             ram_rd_en;

    // Acceptance uses the registered flags, so at full only the read wins
    // and at empty only the write wins.
    assign wr_acc = write_inc_i && !full_q;
    assign rd_acc = read_inc_i && !empty_q;

    always_comb begin
        wr_ptr_nxt = wr_ptr_q;
        rd_ptr_nxt = rd_ptr_q;
        cnt_nxt    = cnt_q;
        if (clear_i) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            cnt_nxt    = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_nxt = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr_nxt = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
            end
            if (wr_acc && !rd_acc) begin
                cnt_nxt = cnt_q + CNT_ONE;
            end else if (rd_acc && !wr_acc) begin
                cnt_nxt = cnt_q - CNT_ONE;
            end
        end
    end

    // Flags are computed from the next count so they never lag nb_data_o.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= FULL_RST;
            afull_q  <= ALMOST_FULL_RST;
            empty_q  <= EMPTY_RST;
            aempty_q <= ALMOST_EMPTY_RST;
        end else begin
            wr_ptr_q <= wr_ptr_nxt;
            rd_ptr_q <= rd_ptr_nxt;
            cnt_q    <= cnt_nxt;
            full_q   <= (cnt_nxt == CNT_FULL);
            afull_q  <= (cnt_nxt >= CNT_AF);
            empty_q  <= (cnt_nxt == '0);
            aempty_q <= (cnt_nxt <= CNT_AE);
        end
    end

    // FWFT: enable qualifies the combinational head word; registered mode:
    // enable loads the output register, left alone by clear.
    assign ram_rd_en = (FWFT != 0) ? !empty_q : (rd_acc && !clear_i);

    cod5_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .FWFT       (FWFT)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .wr_en   (wr_acc && !clear_i),
        .wr_addr (wr_ptr_q),
        .wr_data (write_data_i),
        .rd_en   (ram_rd_en),
        .rd_addr (rd_ptr_q),
        .rd_data (read_data_o)
    );

`ifdef COD5_SYNC_FIFO_ERR_EN
    logic ovf_q, unf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (clear_i) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (write_inc_i && full_q) begin
                ovf_q <= 1'b1;
            end
            if (read_inc_i && empty_q) begin
                unf_q <= 1'b1;
            end
        end
    end

    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;
`else
    assign overflow_o  = 1'b0;
    assign underflow_o = 1'b0;
`endif

    assign write_full_o        = full_q;
    assign write_almost_full_o = afull_q;
    assign read_empty_o        = empty_q;
    assign read_almost_empty_o = aempty_q;
    assign nb_data_o           = cnt_q;

endmodule

// File: tb/tb_cod5_sync_fifo.sv
// Bench for cod5_sync_fifo: FWFT=1 and FWFT=0 instances share stimulus and are checked
// against a queue-based reference model, plus a vector table and corner sequences.
module tb_cod5_sync_fifo;

    localparam int DW    = 16;
    localparam int DEPTH = 24;
    localparam int AF    = 4;
    localparam int AE    = 4;
`ifdef COD5_SYNC_FIFO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          clear_i = 1'b0;
    logic          write_inc_i = 1'b0;
    logic [DW-1:0] write_data_i = '0;
    logic          read_inc_i = 1'b0;

    logic          a_full, a_afull, a_empty, a_aempty, a_ovf, a_unf;
    logic [DW-1:0] a_rd;
    logic [4:0]    a_nb;
    logic          b_full, b_afull, b_empty, b_aempty, b_ovf, b_unf;
    logic [DW-1:0] b_rd;
    logic [4:0]    b_nb;

    always #5 clk_i = ~clk_i;

    cod5_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ALMOST_FULL(AF), .ALMOST_EMPTY(AE), .FWFT(1)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .write_inc_i(write_inc_i), .write_data_i(write_data_i),
        .write_full_o(a_full), .write_almost_full_o(a_afull),
        .read_inc_i(read_inc_i), .read_data_o(a_rd),
        .read_empty_o(a_empty), .read_almost_empty_o(a_aempty),
        .nb_data_o(a_nb), .overflow_o(a_ovf), .underflow_o(a_unf)
    );

    cod5_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ALMOST_FULL(AF), .ALMOST_EMPTY(AE), .FWFT(0)) u_dut_reg (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .write_inc_i(write_inc_i), .write_data_i(write_data_i),
        .write_full_o(b_full), .write_almost_full_o(b_afull),
        .read_inc_i(read_inc_i), .read_data_o(b_rd),
        .read_empty_o(b_empty), .read_almost_empty_o(b_aempty),
        .nb_data_o(b_nb), .overflow_o(b_ovf), .underflow_o(b_unf)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: contents as a queue, last popped word, sticky errors.
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_rd0 = '0;
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_rd0 = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_edge(input logic c, input logic w, input logic [DW-1:0] d, input logic r);
        int n;
        n = m_q.size();
        if (c) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (w && n == DEPTH) m_ovf = 1'b1;
            if (r && n == 0)     m_unf = 1'b1;
            if (r && n != 0)     m_rd0 = m_q.pop_front();
            if (w && n != DEPTH) m_q.push_back(d);
        end
    endtask

    task automatic compare_all();
        int n;
        n = m_q.size();
        chk("nb", 32'(a_nb), 32'(n));
        chk("full", 32'(a_full), 32'(n == DEPTH));
        chk("almost_full", 32'(a_afull), 32'(n >= DEPTH - AF));
        chk("empty", 32'(a_empty), 32'(n == 0));
        chk("almost_empty", 32'(a_aempty), 32'(n <= AE));
        chk("overflow", 32'(a_ovf), 32'(ERR_EN && m_ovf));
        chk("underflow", 32'(a_unf), 32'(ERR_EN && m_unf));
        if (n != 0) chk("rd_fwft", 32'(a_rd), 32'(m_q[0]));
        chk("reg_nb", 32'(b_nb), 32'(n));
        chk("reg_empty", 32'(b_empty), 32'(n == 0));
        chk("reg_full", 32'(b_full), 32'(n == DEPTH));
        chk("rd_reg", 32'(b_rd), 32'(m_rd0));
    endtask

    // Drive one cycle of inputs, let the edge happen, update model, compare.
    task automatic step(input logic c, input logic w, input logic [DW-1:0] d, input logic r);
        clear_i      = c;
        write_inc_i  = w;
        write_data_i = d;
        read_inc_i   = r;
        @(posedge clk_i);
        model_edge(c, w, d, r);
        #1;
        compare_all();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_full"}, 32'(a_full), 32'd0);
        chk({tag, "_afull"}, 32'(a_afull), 32'd0);
        chk({tag, "_empty"}, 32'(a_empty), 32'd1);
        chk({tag, "_aempty"}, 32'(a_aempty), 32'd1);
        chk({tag, "_nb"}, 32'(a_nb), 32'd0);
        chk({tag, "_rd"}, 32'(a_rd), 32'd0);
        chk({tag, "_ovf"}, 32'(a_ovf), 32'd0);
        chk({tag, "_unf"}, 32'(a_unf), 32'd0);
        chk({tag, "_reg_rd"}, 32'(b_rd), 32'd0);
        chk({tag, "_reg_nb"}, 32'(b_nb), 32'd0);
    endtask

    // Reset asserted between clock edges, whatever the inputs are doing.
    task automatic do_reset(input string tag);
        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1 check_reset_vals(tag);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        clear_i     = 1'b0;
        write_inc_i = 1'b0;
        read_inc_i  = 1'b0;
        rst_ni      = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic          c;
        logic          w;
        logic [DW-1:0] d;
        logic          r;
        int            nb;
        logic          emp;
        logic [DW-1:0] rda;
        logic [DW-1:0] rdb;
    } vec_t;

    vec_t vt[12];

    initial begin
        int wp[6];
        int rp[6];
        vt[0]  = '{1'b0, 1'b1, 16'h1234, 1'b0, 1, 1'b0, 16'h1234, 16'h0000};
        vt[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 0, 1'b1, 16'h0000, 16'h1234};
        vt[2]  = '{1'b0, 1'b1, 16'h00A1, 1'b0, 1, 1'b0, 16'h00A1, 16'h1234};
        vt[3]  = '{1'b0, 1'b1, 16'h00A2, 1'b0, 2, 1'b0, 16'h00A1, 16'h1234};
        vt[4]  = '{1'b0, 1'b1, 16'h00A3, 1'b0, 3, 1'b0, 16'h00A1, 16'h1234};
        vt[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 2, 1'b0, 16'h00A2, 16'h00A1};
        vt[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 2, 1'b0, 16'h00A2, 16'h00A1};
        vt[7]  = '{1'b0, 1'b1, 16'h00A4, 1'b1, 2, 1'b0, 16'h00A3, 16'h00A2};
        vt[8]  = '{1'b1, 1'b1, 16'h00A5, 1'b0, 0, 1'b1, 16'h0000, 16'h00A2};
        vt[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 0, 1'b1, 16'h0000, 16'h00A2};
        vt[10] = '{1'b0, 1'b1, 16'h00B1, 1'b1, 1, 1'b0, 16'h00B1, 16'h00A2};
        vt[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 0, 1'b1, 16'h0000, 16'h00B1};

        do_reset("rst0");

        for (int i = 0; i < 12; i++) begin
            step(vt[i].c, vt[i].w, vt[i].d, vt[i].r);
            chk($sformatf("vec%0d_nb", i), 32'(a_nb), 32'(vt[i].nb));
            chk($sformatf("vec%0d_empty", i), 32'(a_empty), 32'(vt[i].emp));
            if (!vt[i].emp) chk($sformatf("vec%0d_rd_fwft", i), 32'(a_rd), 32'(vt[i].rda));
            chk($sformatf("vec%0d_rd_reg", i), 32'(b_rd), 32'(vt[i].rdb));
        end

        // Clear together with a write drops the write and resets errors.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'(16'h0500 + i), 1'b0);
        step(1'b1, 1'b1, 16'h0F0F, 1'b0);
        chk("clr_nb", 32'(a_nb), 32'd0);
        chk("clr_empty", 32'(a_empty), 32'd1);
        chk("clr_unf", 32'(a_unf), 32'd0);
        chk("clr_ovf", 32'(a_ovf), 32'd0);

        // Fill to full from reset, then overflow attempt.
        do_reset("rst1");
        for (int i = 1; i <= DEPTH; i++) step(1'b0, 1'b1, 16'(i), 1'b0);
        chk("fill_full", 32'(a_full), 32'd1);
        chk("fill_nb", 32'(a_nb), 32'd24);
        step(1'b0, 1'b1, 16'hDEAD, 1'b0);
        chk("ovf_nb", 32'(a_nb), 32'd24);
        chk("ovf_flag", 32'(a_ovf), 32'(ERR_EN));
        chk("ovf_head", 32'(a_rd), 32'h0001);
        step(1'b0, 1'b1, 16'hBEEF, 1'b1);
        chk("full_rw_nb", 32'(a_nb), 32'd23);

        // Steady simultaneous read/write across the pointer wrap.
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 16'(16'h1000 + i), 1'b0);
        for (int i = 10; i < 60; i++) step(1'b0, 1'b1, 16'(16'h1000 + i), 1'b1);
        chk("stream_nb", 32'(a_nb), 32'd10);
        chk("stream_head", 32'(a_rd), 32'h1032);

        // Registered read: data appears one cycle after the pop and holds.
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, 16'(16'h0300 + i), 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("reg_pop", 32'(b_rd), 32'h0301);
        repeat (3) step(1'b0, 1'b0, 16'h0000, 1'b0);
        chk("reg_hold", 32'(b_rd), 32'h0301);

        // Reset in the middle of a write burst loses the in-flight word.
        write_inc_i  = 1'b1;
        write_data_i = 16'h7777;
        do_reset("rst_mid");
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        chk("post_rst_nb", 32'(a_nb), 32'd0);

        // Randomized traffic with varying fill bias.
        wp = '{70, 30, 50, 95, 5, 50};
        rp = '{30, 70, 50, 40, 60, 50};
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 400; i++) begin
                step($urandom_range(0, 199) == 0,
                     $urandom_range(0, 99) < wp[p],
                     16'($urandom),
                     $urandom_range(0, 99) < rp[p]);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/cod5_sync_fifo.md
COD5_SYNC_FIFO -- requirements
Module: cod5_sync_fifo

Interface
REQ-001 DATA_WIDTH, 16, word width in bits.
REQ-002 DEPTH, 24, number of storage words; any value 2..1024, not restricted to powers of two.
REQ-003 ALMOST_FULL, 4, almost-full asserts when free slots <= this value; range 0..DEPTH-1.
REQ-004 ALMOST_EMPTY, 4, almost-empty asserts when stored words <= this value; range 0..DEPTH-1.
REQ-005 FWFT, 1, 1 = first-word-fall-through read; 0 = registered read on request.
REQ-006 Clock and reset: one clock; reset is asynchronous and active-low. Ports are clk_i and rst_ni.
REQ-007 clk_i  in  1  sole clock; all state is rising-edge.
REQ-008 rst_ni  in  1  asynchronous active-low reset.
REQ-009 clear_i  in  1  synchronous flush.
REQ-010 write_inc_i  in  1  write request.
REQ-011 write_data_i  in  DATA_WIDTH  write word.
REQ-012 write_full_o  out  1  no free slot.
REQ-013 write_almost_full_o  out  1  free slots <= ALMOST_FULL.
REQ-014 read_inc_i  in  1  read request (pop).
REQ-015 read_data_o  out  DATA_WIDTH  read word.
REQ-016 read_empty_o  out  1  no stored word.
REQ-017 read_almost_empty_o  out  1  stored words <= ALMOST_EMPTY.
REQ-018 nb_data_o  out  clog2(DEPTH+1)  stored-word count, 0..DEPTH inclusive.
REQ-019 overflow_o  out  1  sticky write-while-full error.
REQ-020 underflow_o  out  1  sticky read-while-empty error.

Function
REQ-021 Write is accepted iff write_inc_i && !write_full_o; the word is stored at the write pointer, which then advances.
REQ-022 Read is accepted iff read_inc_i && !read_empty_o; the read pointer then advances.
REQ-023 Pointers wrap from DEPTH-1 to 0; no power-of-two arithmetic is permitted.
REQ-024 nb_data_o is registered: +1 on write-only, -1 on read-only, unchanged on simultaneous accepted read and write.
REQ-025 All flags are registered and derived from the next count in the same edge as nb_data_o, with no lag between flags and count.
REQ-026 Flag definitions: full = (count == DEPTH); empty = (count == 0); almost_full = (count >= DEPTH-ALMOST_FULL); almost_empty = (count <= ALMOST_EMPTY).
REQ-027 At full, a simultaneous write and read accepts the read only; the write is dropped.
REQ-028 At empty, a simultaneous write and read accepts the write only.
REQ-029 FWFT=1: read_data_o shows the head word whenever read_empty_o=0; the first word is visible one cycle after its write is accepted into an empty FIFO.
REQ-030 FWFT=1: read_data_o is don't-care while empty.
REQ-031 FWFT=0: read_data_o updates on the edge following an accepted read and holds otherwise.
REQ-032 clear_i has priority over reads and writes: pointers and count go to 0 and flags go to their reset values on the next edge; storage contents and read_data_o are untouched.

Reset
REQ-033 While rst_ni=0: write_full_o=0, write_almost_full_o=0, read_empty_o=1, read_almost_empty_o=1, nb_data_o=0, read_data_o=0, overflow_o=0, underflow_o=0, and both pointers=0.
REQ-034 Assertion of rst_ni is asynchronous mid-transfer; any in-flight write is lost.
REQ-035 Storage memory is not reset.

Configuration
REQ-036 Macro COD5_SYNC_FIFO_ERR_EN enables the error flags.
REQ-037 With COD5_SYNC_FIFO_ERR_EN: overflow_o sets on write_inc_i && write_full_o; underflow_o sets on read_inc_i && read_empty_o; both clear only on reset or clear_i.
REQ-038 Without COD5_SYNC_FIFO_ERR_EN: overflow_o and underflow_o are present and tied to 0; no error logic is built.
REQ-039 Illegal parameter values (DEPTH<2, thresholds >= DEPTH) cause an elaboration error.

Structure
REQ-040 Package cod5_fifo_pkg holds the clog2 width function, the count-width helper and the flag reset constants, shared with cod5_async_fifo successors.
REQ-041 Sub-module cod5_fifo_ram is a simple dual-port RAM (synchronous write, read port selectable combinational/registered by FWFT); all control stays in cod5_sync_fifo.

Verification
REQ-042 Reset, then write 24 words 0x0001..0x0018 -> write_full_o=1 and nb_data_o=24 on the edge after the 24th write; write_almost_full_o=1 from count 20.
REQ-043 From full, write_inc_i=1 with 0xDEAD -> nb_data_o stays 24, word is discarded, overflow_o=1 (ERR_EN) or 0 (no ERR_EN).
REQ-044 FWFT=1, write 0x1234 into empty -> read_empty_o=0 and read_data_o=0x1234 one cycle later; pop -> read_empty_o=1 next cycle.
REQ-045 Fill 10 words, hold write_inc_i=read_inc_i=1 for 50 cycles with incrementing data -> nb_data_o stays 10; output sequence is in order across pointer wrap at 23->0.
REQ-046 Fill 5 words, pulse clear_i together with write_inc_i -> next cycle nb_data_o=0, read_empty_o=1, underflow_o/overflow_o=0.
REQ-047 FWFT=0, fill 3 words, pop once -> read_data_o equals the first word exactly one cycle after the pop and holds while read_inc_i=0.
